// File: rtl/coin_acceptor_pkg.sv
// Shared definitions for the coin acceptor front end: coin codes as seen by
// vending_machine, channel state encodings and a width helper.
package coin_acceptor_pkg;

  // Coin code driven onto {I, J}; vending_machine decodes the same values.
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b10,
    COIN_10   = 2'b11
  } coin_code_e;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'b00,
    CH_PRESENT = 2'b01,
    CH_JAM     = 2'b10
  } ch_state_e;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/coin_acceptor_channel.sv
// One coin sensor channel: synchroniser, debounce filter, arming guard and
// coin presence FSM. Emits a one-cycle push for every good coin and a jam level.
//
// state      | meaning
// -----------+------------------------------------------------------------
// CH_IDLE    | no coin in the sensor (or channel not yet armed)
// CH_PRESENT | coin passing; duration counter measures filtered-high time
// CH_JAM     | coin stuck longer than JAM_CYCLES; wait for filtered fall
module coin_acceptor_channel
  import coin_acceptor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int JAM_CYCLES  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sense_i,
  output logic push_o,
  output logic jam_o
);

  localparam int DB_W  = width_for(DEBOUNCE);
  localparam int DUR_W = width_for(JAM_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DUR_W-1:0] DUR_MAX = DUR_W'(JAM_CYCLES);
  localparam logic [DUR_W-1:0] DUR_JAM = DUR_W'(JAM_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   sync_lvl;
  logic                   primed;
  logic                   filt_q, filt_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   armed_q, armed_d;
  ch_state_e              state_q, state_d;
  logic [DUR_W-1:0]       dur_q, dur_d;
  logic                   push_q, push_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  // primed marks the point where the synchroniser output reflects the pin
  // rather than its reset value, so arming never trusts the reset zeros.
  assign primed   = primed_q[SYNC_STAGES-1];

  // Synchroniser chain and its parallel "output is valid" shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sense_i};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Debounce: follow the synchronised level after DEBOUNCE stable differing cycles.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync_lvl != filt_q) begin
      if (db_cnt_q == DB_LAST) begin
        filt_d = sync_lvl;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Arm only once the pin is seen low, so a sensor held through reset is ignored.
  always_comb begin
    armed_d = armed_q | (primed & ~sync_lvl & ~filt_q);
  end

  // Coin presence FSM: next state, duration counter and push request.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    push_d  = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (filt_q && armed_q) begin
          state_d = CH_PRESENT;
          dur_d   = '0;
        end
      end
      CH_PRESENT: begin
        if (!filt_q) begin
          state_d = CH_IDLE;
          push_d  = (dur_q < DUR_MAX);
        end else begin
          dur_d = (dur_q == DUR_MAX) ? dur_q : dur_q + 1'b1;
          if (dur_q == DUR_JAM) begin
            state_d = CH_JAM;
          end
        end
      end
      CH_JAM: begin
        if (!filt_q) begin
          state_d = CH_IDLE;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  // Filter, arming and FSM registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
      armed_q  <= 1'b0;
      state_q  <= CH_IDLE;
      dur_q    <= '0;
      push_q   <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
      armed_q  <= armed_d;
      state_q  <= state_d;
      dur_q    <= dur_d;
      push_q   <= push_d;
    end
  end

  assign push_o = push_q;
  assign jam_o  = (state_q == CH_JAM);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two sensor channels, push arbitration (A before B),
// coin FIFO and paced issue of one-cycle coin codes on I/J to vending_machine.
// FIFO_DEPTH must be a power of two, at least 2.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int JAM_CYCLES  = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP         = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sense_a,
  input  logic                          sense_b,
  output logic                          I,
  output logic                          J,
  output logic                          reject,
  output logic                          jam,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int GAP_W = width_for(GAP);

  logic             push_a, push_b, jam_a, jam_b;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  coin_code_e       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count;
  logic             full, empty, pop;
  logic             push_req, push_ok;
  coin_code_e       push_code;
  logic [GAP_W-1:0] gap_q, gap_d;
  coin_code_e       issue_q, issue_d;
  logic             reject_q, reject_d;

  coin_acceptor_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .JAM_CYCLES  (JAM_CYCLES)
  ) u_chan_a (
    .clk     (clk),
    .rst     (rst),
    .sense_i (sense_a),
    .push_o  (push_a),
    .jam_o   (jam_a)
  );

  coin_acceptor_channel #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE    (DEBOUNCE),
    .JAM_CYCLES  (JAM_CYCLES)
  ) u_chan_b (
    .clk     (clk),
    .rst     (rst),
    .sense_i (sense_b),
    .push_o  (push_b),
    .jam_o   (jam_b)
  );

  // Arbitration, FIFO bookkeeping and issue pacing.
  always_comb begin
    count     = wr_ptr_q - rd_ptr_q;
    full      = (count == PW'(FIFO_DEPTH));
    empty     = (count == '0);
    pop       = !empty && (gap_q == '0);
    push_req  = pend_a_q | pend_b_q;
    push_code = pend_a_q ? COIN_5 : COIN_10;
    // A full FIFO still takes the coin when the head leaves in the same cycle.
    push_ok   = push_req && (!full || pop);
    // A pending coin is always consumed on its turn, accepted or dropped.
    pend_a_d  = push_a;
    pend_b_d  = (pend_b_q & pend_a_q) | push_b;
    wr_ptr_d  = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    issue_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : COIN_NONE;
    reject_d  = push_req && full && !pop;
    gap_d     = gap_q;
    if (pop) begin
      gap_d = GAP_W'(GAP);
    end else if (gap_q != '0) begin
      gap_d = gap_q - 1'b1;
    end
  end

  // Control registers; coin storage itself needs no reset since pointers gate it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      gap_q    <= '0;
      issue_q  <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q    <= gap_d;
      issue_q  <= issue_d;
      reject_q <= reject_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_code;
    end
  end

  assign I          = issue_q[1];
  assign J          = issue_q[0];
  assign reject     = reject_q;
  assign jam        = jam_a | jam_b;
  assign fifo_count = count;

endmodule
